// File: rtl/mem_port_arbiter.sv
// Two-port round-robin front end for the SRAM controller. It issues one command at a
// time, returns read data after RD_LAT cycles, and grants nothing while BIST owns the array.
module mem_port_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 16,
  parameter int DW     = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          P0_REQ,
  input  logic          P0_WE,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [DW-1:0] P0_WDATA,
  output logic          P0_ACK,
  output logic          P0_RVALID,
  output logic [DW-1:0] P0_RDATA,
  input  logic          P1_REQ,
  input  logic          P1_WE,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [DW-1:0] P1_WDATA,
  output logic          P1_ACK,
  output logic          P1_RVALID,
  output logic [DW-1:0] P1_RDATA,
  input  logic          BIST_EN,
  input  logic [DW-1:0] ODATA,
  output logic [AW-1:0] ADDR,
  output logic          CE,
  output logic          CSB,
  output logic          WEB,
  output logic          OEB,
  output logic [DW-1:0] IDATA,
  output logic          BUSY
);
  typedef enum logic [1:0] {IDLE, CMD, RWAIT, RESP} state_t;
  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  logic       last_grant;
  logic       owner;
  logic       op_we;
  logic [2:0] wait_cnt;
  logic       pick_p1;

  // Port1 wins when it requests alone, or on a tie when port0 held the last grant.
  always_comb pick_p1 = P1_REQ && (!P0_REQ || !last_grant);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_we      <= 1'b0;
      wait_cnt   <= 3'd0;
      P0_ACK     <= 1'b0;
      P1_ACK     <= 1'b0;
      P0_RVALID  <= 1'b0;
      P1_RVALID  <= 1'b0;
      P0_RDATA   <= '0;
      P1_RDATA   <= '0;
      ADDR       <= '0;
      IDATA      <= '0;
      CE         <= 1'b0;
      CSB        <= 1'b1;
      WEB        <= 1'b1;
      OEB        <= 1'b1;
      BUSY       <= 1'b0;
    end else begin
      P0_ACK    <= 1'b0;
      P1_ACK    <= 1'b0;
      P0_RVALID <= 1'b0;
      P1_RVALID <= 1'b0;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      case (state)
        IDLE: begin
          if (!BIST_EN && (P0_REQ || P1_REQ)) begin
            owner      <= pick_p1;
            last_grant <= pick_p1;
            op_we      <= pick_p1 ? P1_WE : P0_WE;
            ADDR       <= pick_p1 ? P1_ADDR : P0_ADDR;
            IDATA      <= pick_p1 ? P1_WDATA : P0_WDATA;
            P0_ACK     <= !pick_p1;
            P1_ACK     <= pick_p1;
            CE         <= 1'b1;
            CSB        <= 1'b0;
            WEB        <= pick_p1 ? !P1_WE : !P0_WE;
            OEB        <= pick_p1 ? P1_WE : P0_WE;
            BUSY       <= 1'b1;
            state      <= CMD;
          end
        end
        CMD: begin
          if (op_we) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            OEB      <= 1'b0;
            wait_cnt <= 3'd1;
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          // ODATA is valid in the cycle where the count reaches the latency.
          if (wait_cnt >= LAT) begin
            if (owner) begin
              P1_RDATA  <= ODATA;
              P1_RVALID <= 1'b1;
            end else begin
              P0_RDATA  <= ODATA;
              P0_RVALID <= 1'b1;
            end
            state <= RESP;
          end else begin
            OEB <= 1'b0;
            if (wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
